// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
//   Trace capture that snoops the MEM/WB write-back port and stores
//   time-stamped retire events in a DEPTH-entry circular buffer. The capture
//   modes are free-running wrap, stop-on-full and triggered with a post-trigger
//   window. A finished trace is drained oldest-first over a valid/ready port.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-low reset
//   cfg_mode        0 OFF, 1 WRAP, 2 STOP_FULL, 3 TRIGGER
//   cfg_trig_dest   register index that fires the trigger
//   cfg_post_cnt    events kept after the trigger (clamped to DEPTH-1)
//   arm             one-cycle pulse: flush the buffer and start capturing
//   wb_en/wb_dest/wb_data/wb_pc   snooped write-back port
//   rd_ready        consumer accepts rd_entry
//   rd_valid        rd_entry holds the oldest unread entry (DONE only)
//   rd_entry        {stamp, pc, dest, data}
//   count           entries held, 0..DEPTH
//   state           0 IDLE, 1 CAPTURE, 2 POST, 3 DONE
//   overflow        sticky: an entry was overwritten since the last arm
//   done            state == DONE
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
   parameter  int DATA_W  = 32,
   parameter  int ADDR_W  = 5,
   parameter  int PC_W    = 32,
   parameter  int DEPTH   = 16,
   parameter  int CYC_W   = 16,
   localparam int CNT_W   = $clog2(DEPTH) + 1,
   localparam int ENTRY_W = CYC_W + PC_W + ADDR_W + DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         cfg_mode,
   input  logic [ADDR_W-1:0]  cfg_trig_dest,
   input  logic [CNT_W-1:0]   cfg_post_cnt,
   input  logic               arm,
   input  logic               wb_en,
   input  logic [ADDR_W-1:0]  wb_dest,
   input  logic [DATA_W-1:0]  wb_data,
   input  logic [PC_W-1:0]    wb_pc,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [CNT_W-1:0]   count,
   output logic [1:0]         state,
   output logic               overflow,
   output logic               done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;
   typedef enum logic [1:0] {MODE_OFF, MODE_WRAP, MODE_STOP, MODE_TRIG} mode_t;

   state_t             fsm, fsm_nxt;
   mode_t              mode;
   logic               qual, full, wr_fire, clear, post_load, post_dec, pop;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CNT_W-1:0]   count_nxt, post_ctr, post_init;
   logic [CYC_W-1:0]   cyc;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] mem [DEPTH];

   assign mode      = mode_t'(cfg_mode);
   assign qual      = wb_en && (wb_dest != '0);
   assign full      = (count == FULL_CNT);
   assign post_init = (cfg_post_cnt > LAST_CNT) ? LAST_CNT : cfg_post_cnt;
   assign wr_entry  = {cyc, wb_pc, wb_dest, wb_data};
   assign pop       = (fsm == DONE) && rd_valid && rd_ready;
   assign state     = fsm;
   assign done      = (fsm == DONE);

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state is updated with <= so every register samples
      // pre-edge values regardless of the order the blocks are evaluated in.
      if (!rst) fsm <= IDLE;
      else      fsm <= fsm_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      fsm_nxt   = fsm;
      wr_fire   = 1'b0;
      clear     = 1'b0;
      post_load = 1'b0;
      post_dec  = 1'b0;
      if (arm && mode != MODE_OFF) begin
         // A re-arm wins over everything; the coincident event is dropped.
         fsm_nxt = CAPTURE;
         clear   = 1'b1;
      end else begin
         unique case (fsm)
            CAPTURE: begin
               if (mode == MODE_OFF) begin
                  fsm_nxt = DONE;
               end else if (qual) begin
                  unique case (mode)
                     MODE_STOP: begin
                        if (full) begin
                           fsm_nxt = DONE;
                        end else begin
                           wr_fire = 1'b1;
                           if (count == LAST_CNT) fsm_nxt = DONE;
                        end
                     end
                     MODE_TRIG: begin
                        wr_fire = 1'b1;
                        if (wb_dest == cfg_trig_dest) begin
                           if (post_init == '0) begin
                              fsm_nxt = DONE;
                           end else begin
                              fsm_nxt   = POST;
                              post_load = 1'b1;
                           end
                        end
                     end
                     default: wr_fire = 1'b1;
                  endcase
               end
            end
            POST: begin
               if (mode == MODE_OFF) begin
                  fsm_nxt = DONE;
               end else if (qual) begin
                  wr_fire  = 1'b1;
                  post_dec = 1'b1;
                  if (post_ctr == CNT_W'(1)) fsm_nxt = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Pointer / occupancy update. A write into a full buffer overwrites the
   // oldest entry, so the read pointer moves with it and count saturates.
   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      count_nxt  = count;
      if (clear) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else if (wr_fire) begin
         wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (full) rd_ptr_nxt = rd_ptr + PTR_W'(1);
         else      count_nxt  = count + CNT_W'(1);
      end else if (pop) begin
         rd_ptr_nxt = rd_ptr + PTR_W'(1);
         count_nxt  = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         post_ctr <= '0;
         cyc      <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_entry <= '0;
      end else begin
         cyc    <= cyc + CYC_W'(1);
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         if (clear)                overflow <= 1'b0;
         else if (wr_fire && full) overflow <= 1'b1;
         if (post_load)     post_ctr <= post_init;
         else if (post_dec) post_ctr <= post_ctr - CNT_W'(1);
         rd_valid <= (fsm_nxt == DONE) && (count_nxt != '0);
         // Prefetch the head for the next cycle so pops run back-to-back.
         // The bypass covers the head slot being written on this same edge.
         if (fsm_nxt == DONE && count_nxt != '0)
            rd_entry <= (wr_fire && wr_ptr == rd_ptr_nxt) ? wr_entry : mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; count and the pointers decide
      // which slots hold valid data, so stale contents are never exposed.
      if (wr_fire) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_wb_trace_buffer
//   Drives a DEPTH=4 and a DEPTH=8 instance from the same stimulus. Each cycle
//   both are compared against a queue-based trace model. Directed table rows
//   and hand sequences cover stop-on-full, wrap, trigger, dropped events,
//   back-to-back draining and an asynchronous reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_wb_trace_buffer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int PC_W   = 32;
   localparam int CYC_W  = 16;
   localparam int EW     = CYC_W + PC_W + ADDR_W + DATA_W;

   typedef logic [EW-1:0] entry_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [1:0]        cfg_mode;
   logic [ADDR_W-1:0] cfg_trig_dest;
   logic [3:0]        cfg_post_cnt;
   logic              arm, wb_en, rd_ready;
   logic [ADDR_W-1:0] wb_dest;
   logic [DATA_W-1:0] wb_data;
   logic [PC_W-1:0]   wb_pc;

   logic       rd_valid4, overflow4, done4;
   entry_t     rd_entry4;
   logic [2:0] count4;
   logic [1:0] state4;
   logic       rd_valid8, overflow8, done8;
   entry_t     rd_entry8;
   logic [3:0] count8;
   logic [1:0] state8;

   always #5 clk = ~clk;

   wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(4), .CYC_W(CYC_W)) dut4 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_trig_dest(cfg_trig_dest),
      .cfg_post_cnt(cfg_post_cnt[2:0]), .arm(arm), .wb_en(wb_en), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_pc(wb_pc), .rd_ready(rd_ready), .rd_valid(rd_valid4),
      .rd_entry(rd_entry4), .count(count4), .state(state4), .overflow(overflow4), .done(done4)
   );

   wb_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(8), .CYC_W(CYC_W)) dut8 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_trig_dest(cfg_trig_dest),
      .cfg_post_cnt(cfg_post_cnt), .arm(arm), .wb_en(wb_en), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_pc(wb_pc), .rd_ready(rd_ready), .rd_valid(rd_valid8),
      .rd_entry(rd_entry8), .count(count8), .state(state8), .overflow(overflow8), .done(done8)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model (index 0: DEPTH 4, 1: DEPTH 8) --------
   entry_t      m_q [2][$];
   int          m_phase [2];   // 0 idle, 1 capture, 2 post, 3 done
   int          m_post [2];
   logic        m_ovf [2];
   logic        m_valid [2];
   entry_t      m_ent [2];
   logic [15:0] m_cyc;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_q[k].delete();
         m_phase[k] = 0;
         m_post[k]  = 0;
         m_ovf[k]   = 1'b0;
         m_valid[k] = 1'b0;
         m_ent[k]   = '0;
      end
      m_cyc = '0;
   endtask

   task automatic model_step(input int k);
      int     d, pl;
      entry_t e;
      logic   qual;
      d    = (k == 0) ? 4 : 8;
      qual = wb_en && (wb_dest != 0);
      e    = {m_cyc, wb_pc, wb_dest, wb_data};
      if (arm && cfg_mode != 2'd0) begin
         m_q[k].delete();
         m_ovf[k]   = 1'b0;
         m_phase[k] = 1;
      end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
         if (cfg_mode == 2'd0) begin
            m_phase[k] = 3;
         end else if (qual) begin
            if (m_phase[k] == 1 && cfg_mode == 2'd2) begin
               if (m_q[k].size() < d) m_q[k].push_back(e);
               if (m_q[k].size() == d) m_phase[k] = 3;
            end else begin
               if (m_q[k].size() == d) begin
                  void'(m_q[k].pop_front());
                  m_ovf[k] = 1'b1;
               end
               m_q[k].push_back(e);
               if (m_phase[k] == 2) begin
                  m_post[k]--;
                  if (m_post[k] == 0) m_phase[k] = 3;
               end else if (cfg_mode == 2'd3 && wb_dest == cfg_trig_dest) begin
                  pl = (k == 0) ? int'(cfg_post_cnt[2:0]) : int'(cfg_post_cnt);
                  if (pl > d - 1) pl = d - 1;
                  m_post[k]  = pl;
                  m_phase[k] = (pl == 0) ? 3 : 2;
               end
            end
         end
      end else if (m_phase[k] == 3 && m_valid[k] && rd_ready) begin
         void'(m_q[k].pop_front());
      end
      m_valid[k] = (m_phase[k] == 3) && (m_q[k].size() != 0);
      if (m_valid[k]) m_ent[k] = m_q[k][0];
   endtask

   // ---------------- checking -----------------------------------------------
   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] f_dest(input entry_t e);
      return e[DATA_W +: ADDR_W];
   endfunction

   function automatic logic [DATA_W-1:0] f_data(input entry_t e);
      return e[DATA_W-1:0];
   endfunction

   function automatic logic [CYC_W-1:0] f_stamp(input entry_t e);
      return e[EW-1 -: CYC_W];
   endfunction

   task automatic compare_model();
      check("d4.rd_valid", 96'(rd_valid4), 96'(m_valid[0]));
      check("d4.rd_entry", 96'(rd_entry4), 96'(m_ent[0]));
      check("d4.count",    96'(count4),    96'(m_q[0].size()));
      check("d4.state",    96'(state4),    96'(m_phase[0]));
      check("d4.overflow", 96'(overflow4), 96'(m_ovf[0]));
      check("d4.done",     96'(done4),     96'(m_phase[0] == 3));
      check("d8.rd_valid", 96'(rd_valid8), 96'(m_valid[1]));
      check("d8.rd_entry", 96'(rd_entry8), 96'(m_ent[1]));
      check("d8.count",    96'(count8),    96'(m_q[1].size()));
      check("d8.state",    96'(state8),    96'(m_phase[1]));
      check("d8.overflow", 96'(overflow8), 96'(m_ovf[1]));
      check("d8.done",     96'(done8),     96'(m_phase[1] == 3));
   endtask

   // One clock: the model consumes the same pre-edge inputs as the DUTs,
   // outputs are compared 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         model_step(0);
         model_step(1);
         m_cyc = m_cyc + 16'd1;
      end
      #1;
      compare_model();
   endtask

   task automatic ev(input logic en, input logic [ADDR_W-1:0] d);
      wb_en   = en;
      wb_dest = d;
      wb_data = 32'(d) << 4;
      wb_pc   = 32'h0040_0000 + 32'(d) * 32'd4;
   endtask

   // ---------------- directed table (expectations for the DEPTH-4 instance) -
   typedef struct {
      logic [1:0]        mode;
      logic              arm;
      logic              en;
      logic [ADDR_W-1:0] dest;
      logic [2:0]        e_cnt;
      logic [1:0]        e_st;
      logic              e_ovf;
      logic              e_vld;
   } vec_t;

   vec_t        tbl [15];
   logic [15:0] t_first;
   int          t3_dest [7];
   int          t3_st [7];
   int          t3_rd [6];

   initial begin
      // stop-on-full: arm, then dest 1..6
      tbl[0]  = '{2'd2, 1'b1, 1'b0, 5'd0, 3'd0, 2'd1, 1'b0, 1'b0};
      tbl[1]  = '{2'd2, 1'b0, 1'b1, 5'd1, 3'd1, 2'd1, 1'b0, 1'b0};
      tbl[2]  = '{2'd2, 1'b0, 1'b1, 5'd2, 3'd2, 2'd1, 1'b0, 1'b0};
      tbl[3]  = '{2'd2, 1'b0, 1'b1, 5'd3, 3'd3, 2'd1, 1'b0, 1'b0};
      tbl[4]  = '{2'd2, 1'b0, 1'b1, 5'd4, 3'd4, 2'd3, 1'b0, 1'b1};
      tbl[5]  = '{2'd2, 1'b0, 1'b1, 5'd5, 3'd4, 2'd3, 1'b0, 1'b1};
      tbl[6]  = '{2'd2, 1'b0, 1'b1, 5'd6, 3'd4, 2'd3, 1'b0, 1'b1};
      // wrap: arm, dest 1..6, then manual stop
      tbl[7]  = '{2'd1, 1'b1, 1'b0, 5'd0, 3'd0, 2'd1, 1'b0, 1'b0};
      tbl[8]  = '{2'd1, 1'b0, 1'b1, 5'd1, 3'd1, 2'd1, 1'b0, 1'b0};
      tbl[9]  = '{2'd1, 1'b0, 1'b1, 5'd2, 3'd2, 2'd1, 1'b0, 1'b0};
      tbl[10] = '{2'd1, 1'b0, 1'b1, 5'd3, 3'd3, 2'd1, 1'b0, 1'b0};
      tbl[11] = '{2'd1, 1'b0, 1'b1, 5'd4, 3'd4, 2'd1, 1'b0, 1'b0};
      tbl[12] = '{2'd1, 1'b0, 1'b1, 5'd5, 3'd4, 2'd1, 1'b1, 1'b0};
      tbl[13] = '{2'd1, 1'b0, 1'b1, 5'd6, 3'd4, 2'd1, 1'b1, 1'b0};
      tbl[14] = '{2'd0, 1'b0, 1'b0, 5'd0, 3'd4, 2'd3, 1'b1, 1'b1};
      t3_dest = '{1, 2, 3, 7, 4, 5, 6};
      t3_st   = '{1, 1, 1, 2, 2, 3, 3};
      t3_rd   = '{1, 2, 3, 7, 4, 5};
      t_first = '0;

      cfg_mode = 2'd0; cfg_trig_dest = '0; cfg_post_cnt = '0;
      arm = 1'b0; rd_ready = 1'b0;
      ev(1'b0, 5'd0);

      // Reset state
      #1 rst = 1'b0;
      model_reset();
      #1 compare_model();
      #11 rst = 1'b1;

      // Stop-on-full table rows, then drain 4 entries back-to-back
      for (int i = 0; i <= 6; i++) begin
         cfg_mode = tbl[i].mode;
         arm      = tbl[i].arm;
         ev(tbl[i].en, tbl[i].dest);
         if (tbl[i].en && tbl[i].dest == 5'd1) t_first = m_cyc;
         tick();
         check($sformatf("row%0d.count", i),    96'(count4),    96'(tbl[i].e_cnt));
         check($sformatf("row%0d.state", i),    96'(state4),    96'(tbl[i].e_st));
         check($sformatf("row%0d.overflow", i), 96'(overflow4), 96'(tbl[i].e_ovf));
         check($sformatf("row%0d.rd_valid", i), 96'(rd_valid4), 96'(tbl[i].e_vld));
      end
      arm = 1'b0;
      ev(1'b0, 5'd0);
      rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("stop.rd%0d.valid", i), 96'(rd_valid4), 96'(1));
         check($sformatf("stop.rd%0d.dest", i),  96'(f_dest(rd_entry4)), 96'(i));
         check($sformatf("stop.rd%0d.data", i),  96'(f_data(rd_entry4)), 96'(16 * i));
         check($sformatf("stop.rd%0d.stamp", i), 96'(f_stamp(rd_entry4)), 96'(t_first + 16'(i - 1)));
         tick();
      end
      check("stop.after_drain.valid", 96'(rd_valid4), 96'(0));
      check("stop.after_drain.count", 96'(count4), 96'(0));
      rd_ready = 1'b0;

      // Wrap table rows, then drain: expect dests 3,4,5,6
      for (int i = 7; i <= 14; i++) begin
         cfg_mode = tbl[i].mode;
         arm      = tbl[i].arm;
         ev(tbl[i].en, tbl[i].dest);
         tick();
         check($sformatf("row%0d.count", i),    96'(count4),    96'(tbl[i].e_cnt));
         check($sformatf("row%0d.state", i),    96'(state4),    96'(tbl[i].e_st));
         check($sformatf("row%0d.overflow", i), 96'(overflow4), 96'(tbl[i].e_ovf));
         check($sformatf("row%0d.rd_valid", i), 96'(rd_valid4), 96'(tbl[i].e_vld));
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wrap.rd%0d.dest", i), 96'(f_dest(rd_entry4)), 96'(3 + i));
         tick();
      end
      check("wrap.after_drain.valid", 96'(rd_valid4), 96'(0));
      tick();
      tick();
      rd_ready = 1'b0;

      // Trigger on dest 7 with two post-trigger events
      cfg_trig_dest = 5'd7; cfg_post_cnt = 4'd2; cfg_mode = 2'd3; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 7; i++) begin
         ev(1'b1, 5'(t3_dest[i]));
         tick();
         check($sformatf("trig.ev%0d.state", i), 96'(state8), 96'(t3_st[i]));
         check($sformatf("trig.ev%0d.count", i), 96'(count8), 96'((i < 6) ? i + 1 : 6));
      end
      ev(1'b0, 5'd0);
      check("trig.d4.count", 96'(count4), 96'(4));
      check("trig.d4.overflow", 96'(overflow4), 96'(1));
      check("trig.d8.overflow", 96'(overflow8), 96'(0));
      rd_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("trig.rd%0d.dest", i), 96'(f_dest(rd_entry8)), 96'(t3_rd[i]));
         tick();
      end
      check("trig.after_drain.valid", 96'(rd_valid8), 96'(0));
      check("trig.after_drain.count", 96'(count8), 96'(0));
      rd_ready = 1'b0;

      // Ignored events: coincident with arm, wb_en low, dest 0
      cfg_mode = 2'd1; arm = 1'b1; ev(1'b1, 5'd3);
      tick();
      arm = 1'b0;
      ev(1'b0, 5'd5); tick();
      ev(1'b0, 5'd6); tick();
      ev(1'b1, 5'd0); tick();
      ev(1'b1, 5'd0); tick();
      check("drop.d4.count", 96'(count4), 96'(0));
      check("drop.d8.count", 96'(count8), 96'(0));
      check("drop.d4.state", 96'(state4), 96'(1));

      // Asynchronous reset in the middle of POST, then re-arm
      cfg_trig_dest = 5'd7; cfg_post_cnt = 4'd3; cfg_mode = 2'd3; arm = 1'b1; ev(1'b0, 5'd0);
      tick();
      arm = 1'b0;
      ev(1'b1, 5'd1); tick();
      ev(1'b1, 5'd7); tick();
      ev(1'b1, 5'd4); tick();
      check("post.d8.state", 96'(state8), 96'(2));
      check("post.d4.state", 96'(state4), 96'(2));
      ev(1'b0, 5'd0);
      #3 rst = 1'b0;
      model_reset();
      #1;
      check("rst.d8.state", 96'(state8), 96'(0));
      check("rst.d8.count", 96'(count8), 96'(0));
      check("rst.d4.count", 96'(count4), 96'(0));
      check("rst.d8.entry", 96'(rd_entry8), 96'(0));
      compare_model();
      tick();
      #3 rst = 1'b1;
      cfg_mode = 2'd2; arm = 1'b1;
      tick();
      arm = 1'b0;
      for (int d = 1; d <= 4; d++) begin
         ev(1'b1, 5'(d));
         tick();
      end
      ev(1'b0, 5'd0);
      check("rearm.d4.done", 96'(done4), 96'(1));
      check("rearm.d4.count", 96'(count4), 96'(4));
      check("rearm.d8.state", 96'(state8), 96'(1));
      check("rearm.d8.count", 96'(count8), 96'(4));

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         arm = 1'b0;
         if ($urandom_range(0, 24) == 0) begin
            arm           = 1'b1;
            cfg_mode      = 2'($urandom_range(0, 3));
            cfg_trig_dest = 5'($urandom_range(0, 7));
            cfg_post_cnt  = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 59) == 0) begin
            cfg_mode = 2'd0;
         end
         ev($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)));
         wb_data  = $urandom;
         rd_ready = 1'($urandom_range(0, 1));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
